// File: rtl/mistral_counter.sv
// Up/down modulo-N counter with Cyclone V ALM register controls (ENA gates SCLR/SLOAD/count).
// Wraps or saturates at the ends; EVT flags the cycle after a boundary step.
module mistral_counter #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int              SATURATE = 0
) (
    input  logic             CLK,
    input  logic             AC,
    input  logic             ENA,
    input  logic             SCLR,
    input  logic             SLOAD,
    input  logic [WIDTH-1:0] SDATA,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             EVT
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mistral_counter: WIDTH must be within 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mistral_counter: MODULUS must be within 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_ZERO = '0;
    localparam bit               LP_SAT  = (SATURATE != 0);

    logic [WIDTH-1:0] r_q;
    logic             r_evt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_evt_nxt;
    logic             w_at_top;
    logic             w_at_bot;

    // Loads beyond the modulus land on the top count so Q can never leave 0..MODULUS-1.
    function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] d);
        return (d > LP_MAX) ? LP_MAX : d;
    endfunction

    function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] q);
        if (q == LP_MAX) begin
            return LP_SAT ? q : LP_ZERO;
        end
        return q + LP_ONE;
    endfunction

    function automatic logic [WIDTH-1:0] f_dec(input logic [WIDTH-1:0] q);
        if (q == LP_ZERO) begin
            return LP_SAT ? q : LP_MAX;
        end
        return q - LP_ONE;
    endfunction

    assign w_at_top = (r_q == LP_MAX);
    assign w_at_bot = (r_q == LP_ZERO);

    always_comb begin
        w_q_nxt   = r_q;
        w_evt_nxt = 1'b0;
        if (ENA) begin
            if (SCLR) begin
                w_q_nxt = LP_ZERO;
            end else if (SLOAD) begin
                w_q_nxt = f_clamp(SDATA);
            end else if (UP) begin
                w_q_nxt   = f_inc(r_q);
                w_evt_nxt = w_at_top;
            end else begin
                w_q_nxt   = f_dec(r_q);
                w_evt_nxt = w_at_bot;
            end
        end
    end

    always_ff @(posedge CLK or posedge AC) begin
        if (AC) begin
            r_q   <= '0;
            r_evt <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_evt <= w_evt_nxt;
        end
    end

    assign Q   = r_q;
    assign EVT = r_evt;
    assign TC  = UP ? w_at_top : w_at_bot;

endmodule

// File: tb/tb_mistral_counter.sv
// Bench for mistral_counter: wrap and saturate instances (WIDTH=4, MODULUS=10) share stimulus
// and are compared every cycle against an arithmetic model, plus hand-computed spot checks.
module tb_mistral_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       ac = 1'b0;
    logic       ena = 1'b0;
    logic       sclr = 1'b0;
    logic       sload = 1'b0;
    logic [3:0] sdata = 4'd0;
    logic       up = 1'b1;

    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, evt_w, evt_s;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_en = 1'b0;

    int mw = 0, ms = 0;
    bit ew = 1'b0, es = 1'b0;

    always #5 clk = ~clk;

    mistral_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .CLK(clk), .AC(ac), .ENA(ena), .SCLR(sclr), .SLOAD(sload), .SDATA(sdata), .UP(up),
        .Q(q_w), .TC(tc_w), .EVT(evt_w)
    );

    mistral_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .CLK(clk), .AC(ac), .ENA(ena), .SCLR(sclr), .SLOAD(sload), .SDATA(sdata), .UP(up),
        .Q(q_s), .TC(tc_s), .EVT(evt_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: modular arithmetic for the wrap instance, min/max clamping for the saturating one.
    always @(posedge clk or posedge ac) begin
        if (ac) begin
            mw = 0; ms = 0; ew = 1'b0; es = 1'b0;
        end else begin
            ew = 1'b0; es = 1'b0;
            if (ena) begin
                if (sclr) begin
                    mw = 0; ms = 0;
                end else if (sload) begin
                    mw = (int'(sdata) > M - 1) ? M - 1 : int'(sdata);
                    ms = mw;
                end else if (up) begin
                    ew = (mw == M - 1);
                    mw = (mw + 1) % M;
                    es = (ms == M - 1);
                    ms = (ms + 1 > M - 1) ? M - 1 : ms + 1;
                end else begin
                    ew = (mw == 0);
                    mw = (mw + M - 1) % M;
                    es = (ms == 0);
                    ms = (ms == 0) ? 0 : ms - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wrap_q",   q_w,   mw);
            chk("wrap_evt", evt_w, ew);
            chk("wrap_tc",  tc_w,  up ? (mw == M - 1) : (mw == 0));
            chk("sat_q",    q_s,   ms);
            chk("sat_evt",  evt_s, es);
            chk("sat_tc",   tc_s,  up ? (ms == M - 1) : (ms == 0));
        end
    end

    task automatic step(input logic e, input logic c, input logic l, input logic [3:0] d,
                        input logic u);
        ena = e; sclr = c; sload = l; sdata = d; up = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 ac = 1'b1;
        #1;
        chk("rst_q",   q_w,   0);
        chk("rst_evt", evt_w, 0);
        chk("rst_tc",  tc_w,  0);
        @(posedge clk);
        #1 ac = 1'b0;
        cmp_en = 1'b1;

        // Count up 12 edges from 0: wrap goes 1..9,0,1,2; saturate sticks at 9.
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 4'd0, 1);
            if (i == 9) begin
                chk("up9_q", q_w, 9);
                chk("up9_tc", tc_w, 1);
            end
            if (i == 10) begin
                chk("wrap_q0", q_w, 0);
                chk("wrap_evt1", evt_w, 1);
            end
            if (i >= 10) begin
                chk("sat_hold_q", q_s, 9);
                chk("sat_hold_evt", evt_s, 1);
            end
        end
        chk("up12_q", q_w, 2);

        step(1, 0, 0, 4'd0, 0);
        chk("sat_down_q", q_s, 8);
        chk("sat_down_evt", evt_s, 0);
        chk("wrap_down_q", q_w, 1);

        step(1, 0, 0, 4'd0, 0);
        chk("dn_q0", q_w, 0);
        chk("dn_tc", tc_w, 1);
        step(1, 0, 0, 4'd0, 0);
        chk("dn_wrap_q", q_w, 9);
        chk("dn_wrap_evt", evt_w, 1);
        step(1, 0, 0, 4'd0, 0);
        chk("dn_q8", q_w, 8);
        chk("dn_evt0", evt_w, 0);

        // Async clear between edges while Q=5.
        step(1, 0, 1, 4'd5, 1);
        chk("load5", q_w, 5);
        ena = 1'b1; sload = 1'b0; up = 1'b1;
        ac = 1'b1;
        #1;
        chk("ac_q", q_w, 0);
        chk("ac_evt", evt_w, 0);
        #1 ac = 1'b0;
        step(1, 0, 0, 4'd0, 1);
        chk("resume1", q_w, 1);
        chk("resume_evt", evt_w, 0);
        step(1, 0, 0, 4'd0, 1);
        chk("resume2", q_w, 2);

        // ENA gates clear/load; clear wins over load.
        step(1, 0, 1, 4'd7, 1);
        step(0, 1, 1, 4'd3, 1);
        chk("ena0_q", q_w, 7);
        step(1, 1, 1, 4'd3, 1);
        chk("sclr_q", q_w, 0);

        // Out-of-range load clamps; next up step is a boundary step.
        step(1, 0, 1, 4'd15, 1);
        chk("clamp_q", q_w, 9);
        chk("clamp_evt", evt_w, 0);
        step(1, 0, 0, 4'd0, 1);
        chk("clamp_wrap_q", q_w, 0);
        chk("clamp_wrap_evt", evt_w, 1);
        chk("clamp_sat_evt", evt_s, 1);
        step(0, 0, 0, 4'd0, 1);
        chk("ena0_sat_evt", evt_s, 0);
        chk("ena0_sat_q", q_s, 9);

        // Mixed vectors, checked by the model only.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
